gpu_job_scheduler: RTL and testbench

- Sequences the shared GPU matrix core (16x16 x 32-bit A/B operand buses, flat result bus) among NREQ requesters.
- Arbitrates requests round-robin and steers the operand mux through sel.
- Brackets each job with a GPU_RES pulse, forwards halt, and counts run cycles against a timeout.
- Strobes capture of result_matrix into the winner's result buffer.
- Sits between the host-side job queues and the GPU instance.

---
 rtl/gpu_job_scheduler_if.sv | 44 ++++
 rtl/gpu_job_scheduler.sv | 157 +++++++++++++++
 tb/tb_gpu_job_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gpu_job_scheduler_if.sv
// gpu_job_scheduler_if: job-request, GPU control and completion signals
// shared between the host job queues and the GPU job scheduler.
//   req       host -> sched  per-requester job request (level)
//   hlt_in    host -> sched  halt request
//   gpu_done  gpu  -> sched  completion flag (level)
//   grant     sched -> host  one-hot accept pulse
//   sel       sched -> mux   operand/result select, stable for the job
//   gpu_res   sched -> gpu   GPU_RES
//   gpu_hlt   sched -> gpu   HLT
//   result_we sched -> buf   result capture strobe into buffer[sel]
//   done/err  sched -> host  completion pulse / timeout flag
//   busy      sched -> host  job in flight
//   cycles    sched -> host  RUN-cycle count of last finished job
interface gpu_job_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
);
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic            hlt_in;
  logic            gpu_done;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            gpu_res;
  logic            gpu_hlt;
  logic            result_we;
  logic [NREQ-1:0] done;
  logic            err;
  logic            busy;
  logic [CNTW-1:0] cycles;

  // Host / GPU side
  modport master (
    output req, hlt_in, gpu_done,
    input  grant, sel, gpu_res, gpu_hlt, result_we, done, err, busy, cycles
  );

  // Scheduler side
  modport slave (
    input  req, hlt_in, gpu_done,
    output grant, sel, gpu_res, gpu_hlt, result_we, done, err, busy, cycles
  );
endinterface

// File: rtl/gpu_job_scheduler.sv
// gpu_job_scheduler: round-robin sequencer for the shared GPU matrix core.
// Grants one requester at a time, holds GPU_RES for RESET_HOLD cycles while
// operands settle, runs the job with halt forwarding and a timeout, then
// strobes result capture and pulses done (with err on timeout abort).
//   CLK  clock, rising edge
//   RES  synchronous active-high reset
//   bus  gpu_job_scheduler_if.slave (see interface for signal list)
module gpu_job_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned TIMEOUT    = 10240,
  parameter int unsigned CNTW       = 16
) (
  input logic                CLK,
  input logic                RES,
  gpu_job_scheduler_if.slave bus
);
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_ABORT
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [SELW-1:0] rr_ptr, rr_ptr_nxt;
  logic [SELW-1:0] sel_q, sel_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [NREQ-1:0] done_q, done_nxt;
  logic            gpu_res_q, gpu_res_nxt;
  logic            gpu_hlt_q, gpu_hlt_nxt;
  logic            we_q, we_nxt;
  logic            err_q, err_nxt;
  logic            busy_q, busy_nxt;
  logic [CNTW-1:0] cycles_q, cycles_nxt;

  // Round-robin winner: first set req scanning upward from rr_ptr with wrap
  logic            found;
  logic [SELW-1:0] win;
  logic [SELW:0]   idx_w;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx_w = {1'b0, rr_ptr} + (SELW+1)'(i);
      if (idx_w >= (SELW+1)'(NREQ)) idx_w = idx_w - (SELW+1)'(NREQ);
      if (!found && bus.req[idx_w[SELW-1:0]]) begin
        found = 1'b1;
        win   = idx_w[SELW-1:0];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RES) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      gpu_res_q <= 1'b1;
      gpu_hlt_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      sel_q     <= sel_nxt;
      grant_q   <= grant_nxt;
      done_q    <= done_nxt;
      gpu_res_q <= gpu_res_nxt;
      gpu_hlt_q <= gpu_hlt_nxt;
      we_q      <= we_nxt;
      err_q     <= err_nxt;
      busy_q    <= busy_nxt;
      cycles_q  <= cycles_nxt;
    end
  end

  // Next state and next output values; strobes are set on the transition
  // so they are visible during the CAPTURE/ABORT/grant cycle itself.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rr_ptr_nxt  = rr_ptr;
    sel_nxt     = sel_q;
    grant_nxt   = '0;
    done_nxt    = '0;
    we_nxt      = 1'b0;
    err_nxt     = 1'b0;
    gpu_hlt_nxt = 1'b0;
    cycles_nxt  = cycles_q;

    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt  = S_LOAD;
          grant_nxt  = NREQ'(1) << win;
          sel_nxt    = win;
          rr_ptr_nxt = (win == SELW'(NREQ - 1)) ? '0 : win + SELW'(1);
          cnt_nxt    = '0;
        end
      end
      S_LOAD: begin
        // gpu_done is deliberately ignored while operands settle
        if (cnt == CNTW'(RESET_HOLD - 1)) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNTW'(1);
        end
      end
      S_RUN: begin
        if (!gpu_hlt_q) cnt_nxt = cnt + CNTW'(1);
        // Completion takes priority over a coincident timeout
        if (bus.gpu_done) begin
          state_nxt  = S_CAPTURE;
          done_nxt   = NREQ'(1) << sel_q;
          we_nxt     = 1'b1;
          cycles_nxt = cnt + CNTW'(1);
        end else if (!gpu_hlt_q && cnt == CNTW'(TIMEOUT - 1)) begin
          state_nxt  = S_ABORT;
          done_nxt   = NREQ'(1) << sel_q;
          err_nxt    = 1'b1;
          cycles_nxt = CNTW'(TIMEOUT);
        end else begin
          gpu_hlt_nxt = bus.hlt_in;
        end
      end
      S_CAPTURE, S_ABORT: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    gpu_res_nxt = (state_nxt != S_RUN);
    busy_nxt    = (state_nxt != S_IDLE);
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.gpu_res   = gpu_res_q;
  assign bus.gpu_hlt   = gpu_hlt_q;
  assign bus.result_we = we_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_gpu_job_scheduler.sv
// tb_gpu_job_scheduler: directed scoreboard bench for gpu_job_scheduler
// (NREQ=4, RESET_HOLD=2, TIMEOUT=20). Stimulus pushes expected grant and
// completion records; a negedge monitor pops and compares them.
module tb_gpu_job_scheduler;
  logic CLK = 1'b0;
  logic RES;

  always #5 CLK = ~CLK;

  gpu_job_scheduler_if #(.NREQ(4), .CNTW(16)) ifc ();

  gpu_job_scheduler #(
    .NREQ(4), .RESET_HOLD(2), .TIMEOUT(20), .CNTW(16)
  ) dut (
    .CLK(CLK),
    .RES(RES),
    .bus(ifc.slave)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
  } gexp_t;

  typedef struct packed {
    logic [3:0]  done;
    logic        err;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] cycles;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t ge;
  dexp_t de;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant/done the DUT presents must match the next expectation
  always @(negedge CLK) begin
    if (ifc.grant != '0) begin
      if (gq.size() == 0) check("grant_unexpected", 32'(ifc.grant), 32'd0);
      else begin
        ge = gq.pop_front();
        check("grant", 32'(ifc.grant), 32'(ge.grant));
        check("grant_sel", 32'(ifc.sel), 32'(ge.sel));
      end
    end
    if (ifc.done != '0) begin
      if (dq.size() == 0) check("done_unexpected", 32'(ifc.done), 32'd0);
      else begin
        de = dq.pop_front();
        check("done", 32'(ifc.done), 32'(de.done));
        check("err", 32'(ifc.err), 32'(de.err));
        check("result_we", 32'(ifc.result_we), 32'(de.we));
        check("done_sel", 32'(ifc.sel), 32'(de.sel));
        check("cycles", 32'(ifc.cycles), 32'(de.cycles));
      end
    end else if (ifc.err || ifc.result_we) begin
      check("stray_strobe", 32'({ifc.err, ifc.result_we}), 32'd0);
    end
  end

  // Waits for a grant; returns how many negedges gpu_res was seen high meanwhile
  task automatic wait_grant(output int res_hi, output bit seen);
    res_hi = 0;
    seen   = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      if (ifc.gpu_res) res_hi++;
      seen = (ifc.grant != '0);
    end
    check("grant_seen", 32'(seen), 32'd1);
  endtask

  // One complete job; RUN cycle k is numbered from 1
  task automatic run_job(input logic [3:0] exp_grant, input logic [1:0] exp_sel,
                         input bit drop_req, input bit done_in_load,
                         input int halt_start, input int halt_len, input int done_at,
                         input logic [15:0] exp_cycles, input bit exp_err,
                         input int exp_hlt, output int res_hi);
    int hlt_seen;
    bit seen;
    gq.push_back('{grant: exp_grant, sel: exp_sel});
    dq.push_back('{done: exp_grant, err: exp_err, we: !exp_err, sel: exp_sel,
                   cycles: exp_cycles});
    wait_grant(res_hi, seen);
    if (drop_req) ifc.req = '0;
    if (done_in_load) ifc.gpu_done = 1'b1;
    check("res_load1", 32'(ifc.gpu_res), 32'd1);
    check("busy_load", 32'(ifc.busy), 32'd1);
    @(negedge CLK);
    check("res_load2", 32'(ifc.gpu_res), 32'd1);
    @(negedge CLK);
    check("res_run", 32'(ifc.gpu_res), 32'd0);
    hlt_seen = 0;
    seen     = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (ifc.gpu_hlt) hlt_seen++;
      if (halt_len != 0 && k == halt_start) ifc.hlt_in = 1'b1;
      if (halt_len != 0 && k == halt_start + halt_len) ifc.hlt_in = 1'b0;
      ifc.gpu_done = (k == done_at);
      @(negedge CLK);
      seen = (ifc.done != '0);
    end
    ifc.gpu_done = 1'b0;
    ifc.hlt_in   = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("hlt_cycles", 32'(hlt_seen), 32'(exp_hlt));
    check("res_end", 32'(ifc.gpu_res), 32'd1);
    check("hlt_end", 32'(ifc.gpu_hlt), 32'd0);
  endtask

  task automatic do_reset();
    RES = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RES = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int res_hi;
    bit seen;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    RES = 1'b1;
    ifc.req = '0;
    ifc.hlt_in = 1'b0;
    ifc.gpu_done = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_gpu_res", 32'(ifc.gpu_res), 32'd1);
    check("rst_gpu_hlt", 32'(ifc.gpu_hlt), 32'd0);
    check("rst_grant", 32'(ifc.grant), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_err", 32'(ifc.err), 32'd0);
    check("rst_we", 32'(ifc.result_we), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_sel", 32'(ifc.sel), 32'd0);
    check("rst_cycles", 32'(ifc.cycles), 32'd0);
    RES = 1'b0;

    // Single job on req[1], done on 5th RUN cycle; req dropped mid-job
    ifc.req = 4'b0010;
    run_job(4'b0010, 2'd1, 1'b1, 1'b0, 0, 0, 5, 16'd5, 1'b0, 0, res_hi);
    @(negedge CLK);
    check("idle_busy", 32'(ifc.busy), 32'd0);
    check("idle_res", 32'(ifc.gpu_res), 32'd1);

    // All requesting: round-robin order, gpu_res gap between RUN phases
    do_reset();
    ifc.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job(order[j], 2'(j % 4), 1'b0, 1'b0, 0, 0, 3, 16'd3, 1'b0, 0, res_hi);
      if (j > 0) check("res_gap", 32'(1 + res_hi + 1), 32'd4);
    end
    ifc.req = '0;

    // Halt for 10 cycles mid-RUN (rr_ptr=1, only req[0] asks)
    ifc.req = 4'b0001;
    run_job(4'b0001, 2'd0, 1'b1, 1'b0, 2, 10, 14, 16'd4, 1'b0, 10, res_hi);

    // Timeout abort
    ifc.req = 4'b1000;
    run_job(4'b1000, 2'd3, 1'b1, 1'b0, 0, 0, 0, 16'd20, 1'b1, 0, res_hi);
    @(negedge CLK);
    check("abort_idle_busy", 32'(ifc.busy), 32'd0);
    check("abort_idle_res", 32'(ifc.gpu_res), 32'd1);

    // Reset during RUN of a job on req[2]: no done/err, rr_ptr back to 0
    ifc.req = 4'b0100;
    gq.push_back('{grant: 4'b0100, sel: 2'd2});
    wait_grant(res_hi, seen);
    ifc.req = '0;
    repeat (3) @(negedge CLK);
    check("pre_rst_run", 32'(ifc.gpu_res), 32'd0);
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    check("midrst_res", 32'(ifc.gpu_res), 32'd1);
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_done", 32'(ifc.done), 32'd0);
    check("midrst_err", 32'(ifc.err), 32'd0);
    check("midrst_cycles", 32'(ifc.cycles), 32'd0);
    repeat (3) @(negedge CLK);
    ifc.req = 4'b1100;
    run_job(4'b0100, 2'd2, 1'b1, 1'b0, 0, 0, 2, 16'd2, 1'b0, 0, res_hi);

    // gpu_done high through LOAD and at counter==TIMEOUT-1: CAPTURE wins
    ifc.req = 4'b0010;
    run_job(4'b0010, 2'd1, 1'b1, 1'b1, 0, 0, 20, 16'd20, 1'b0, 0, res_hi);

    repeat (4) @(negedge CLK);
    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("done_queue_empty", 32'(dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
